// File: rtl/gates_pipe.sv
// Two-stage bitwise logic unit (8 opcodes) with accumulator chaining and a saturating result counter.
// Latency: 2 cycles from input handshake to out_valid.
// Backpressure: S2 holds while out_ready=0, S1 then fills and in_ready drops; 1 txn/cycle when unstalled.
`timescale 1ns/1ps
module gates_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_cnt
);

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [2:0]       s1_op_q;
  logic             s1_acc_q;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_hs, out_hs, xfer;
  logic [WIDTH-1:0] op_b, result;

  assign xfer     = s1_vld_q & (~s2_vld_q | out_ready);
  assign in_ready = ~s1_vld_q | xfer;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = s2_vld_q & out_ready;

  // B comes from the accumulator as it stands before this edge, so a same-cycle clear does not affect it.
  always_comb begin
    op_b   = s1_acc_q ? acc_q : s1_b_q;
    result = s1_a_q;
    case (s1_op_q)
      3'd0:    result = s1_a_q & op_b;
      3'd1:    result = s1_a_q | op_b;
      3'd2:    result = ~s1_a_q;
      3'd3:    result = ~(s1_a_q & op_b);
      3'd4:    result = ~(s1_a_q | op_b);
      3'd5:    result = s1_a_q ^ op_b;
      3'd6:    result = ~(s1_a_q ^ op_b);
      default: result = s1_a_q;
    endcase
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (in_hs)     s1_vld_d = 1'b1;
    else if (xfer) s1_vld_d = 1'b0;

    s2_vld_d = s2_vld_q;
    y_d      = y_q;
    zero_d   = zero_q;
    if (xfer) begin
      s2_vld_d = 1'b1;
      y_d      = result;
      zero_d   = (result == '0);
    end else if (out_hs) begin
      s2_vld_d = 1'b0;
    end

    acc_d = acc_q;
    if (acc_clr)   acc_d = '0;
    else if (xfer) acc_d = result;

    cnt_d = cnt_q;
    if (out_hs && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Operand registers need no reset: they are only consumed while s1_vld_q is set.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      s1_a_q   <= in_a;
      s1_b_q   <= in_b;
      s1_op_q  <= in_op;
      s1_acc_q <= in_acc;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_y     = y_q;
  assign out_zero  = zero_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_gates_pipe.sv
// Bench for gates_pipe: in-order result queue model checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_gates_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_acc, acc_clr, out_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_ready, out_valid, out_zero;
  logic [7:0] out_y, out_cnt;
  logic       in_ready2, out_valid2, out_zero2;
  logic [7:0] out_y2;
  logic [1:0] out_cnt2;

  int checks = 0;
  int errors = 0;

  gates_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_cnt(out_cnt)
  );

  gates_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2),
    .out_zero(out_zero2), .out_cnt(out_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gate_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // Model state
  logic [7:0] exp_q[$];
  logic [7:0] log_y[$];
  logic       log_z[$];
  logic [7:0] m_acc = 8'h00;
  int         hs_cnt = 0;
  int         cyc = 0;
  int         first_in = -1;
  int         first_out = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_y = 8'h00;

  always @(negedge clk) begin
    logic [7:0] e, b;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_acc      = 8'h00;
      hs_cnt     = 0;
      prev_stall = 1'b0;
    end else begin
      chk("cnt8", 32'(out_cnt), (hs_cnt > 255) ? 32'd255 : 32'(hs_cnt));
      chk("cnt2", 32'(out_cnt2), (hs_cnt > 3) ? 32'd3 : 32'(hs_cnt));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_y", 32'(out_y), 32'(prev_y));
      end
      if (out_valid && exp_q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_y", 32'(out_y), 32'(e));
        chk("out_zero", 32'(out_zero), 32'(e == 8'h00));
        chk("out_valid2", 32'(out_valid2), 32'd1);
        chk("out_y2", 32'(out_y2), 32'(e));
        chk("out_zero2", 32'(out_zero2), 32'(e == 8'h00));
        log_y.push_back(out_y);
        log_z.push_back(out_zero);
        hs_cnt++;
        if (first_out < 0) first_out = cyc;
      end
      if (acc_clr) m_acc = 8'h00;
      if (in_valid && in_ready) begin
        chk("in_ready2", 32'(in_ready2), 32'd1);
        b = in_acc ? m_acc : in_b;
        e = gate_fn(in_op, in_a, b);
        m_acc = e;
        exp_q.push_back(e);
        if (first_in < 0) first_in = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic acc);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [7:0] ey);
    if (idx < log_y.size()) chk(nm, 32'(log_y[idx]), 32'(ey));
    else chk({nm, "_missing"}, 32'(log_y.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [7:0] t1_exp[8];
    t1_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // All eight functions back-to-back on fixed operands
    log_y.delete(); log_z.delete(); first_in = -1; first_out = -1;
    for (int op = 0; op < 8; op++) send(8'hF0, 8'h3C, 3'(op), 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++) chk_log("t1_y", i, t1_exp[i]);
    chk("t1_latency", 32'(first_out - first_in), 32'd2);
    chk("t1_cnt8", 32'(out_cnt), 32'd8);
    chk("t1_cnt2_sat", 32'(out_cnt2), 32'd3);

    // Accumulator chain; in_b is garbage whenever in_acc=1
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    log_y.delete(); log_z.delete();
    send(8'h01, 8'h55, 3'd1, 1'b1);
    send(8'h02, 8'h55, 3'd1, 1'b1);
    send(8'hFF, 8'h55, 3'd5, 1'b1);
    send(8'hFF, 8'h0F, 3'd0, 1'b0);
    wait_idle();
    chk_log("t2_y0", 0, 8'h01);
    chk_log("t2_y1", 1, 8'h03);
    chk_log("t2_y2", 2, 8'hFC);
    chk_log("t2_y3", 3, 8'h0F);
    if (log_z.size() == 4) chk("t2_zero3", 32'(log_z[3]), 32'd0);

    // Zero flag
    log_y.delete(); log_z.delete();
    send(8'hAA, 8'h55, 3'd0, 1'b0);
    send(8'hAA, 8'h55, 3'd6, 1'b0);
    wait_idle();
    chk_log("t4_y0", 0, 8'h00);
    chk_log("t4_y1", 1, 8'h00);
    if (log_z.size() == 2) begin
      chk("t4_zero0", 32'(log_z[0]), 32'd1);
      chk("t4_zero1", 32'(log_z[1]), 32'd1);
    end else chk("t4_zlog_size", 32'(log_z.size()), 32'd2);

    // Backpressure: two accepted, third blocked until the sink drains
    log_y.delete(); log_z.delete();
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd5, 1'b0);
    send(8'h0F, 8'hF0, 3'd1, 1'b0);
    in_a = 8'h80; in_b = 8'h00; in_op = 3'd2; in_acc = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_in_ready_low", 32'(in_ready), 32'd0);
      chk("t3_out_y_held", 32'(out_y), 32'h26);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
      end
      if (!ok) chk("t3_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    chk_log("t3_y0", 0, 8'h26);
    chk_log("t3_y1", 1, 8'hFF);
    chk_log("t3_y2", 2, 8'h7F);
    chk("t3_count", 32'(log_y.size()), 32'd3);

    // Counter saturation: 17 results so far, 240 more exceeds 255
    for (int i = 0; i < 240; i++) send(8'(i), 8'h00, 3'd7, 1'b0);
    wait_idle();
    chk("sat_cnt8", 32'(out_cnt), 32'd255);
    chk("sat_cnt2", 32'(out_cnt2), 32'd3);

    // Async reset between edges with two results in flight
    out_ready = 1'b0;
    send(8'h5A, 8'h00, 3'd7, 1'b0);
    send(8'hA5, 8'h00, 3'd7, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_cnt", 32'(out_cnt), 32'd0);
    chk("ar_out_zero", 32'(out_zero), 32'd1);
    chk("ar_out_y", 32'(out_y), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    log_y.delete(); log_z.delete();
    send(8'h11, 8'hEE, 3'd1, 1'b1);
    wait_idle();
    chk_log("ar_acc_y", 0, 8'h11);
    chk("ar_count", 32'(log_y.size()), 32'd1);
    chk("ar_cnt8", 32'(out_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
